multi_cycle_ctrl: RTL

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/cpu_ctrl_pkg.sv | 65 ++++++
 rtl/multi_cycle_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the multi-cycle CPU control FSM
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_R     = 6'd0;
    localparam logic [5:0] OP_BLTZ  = 6'd1;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BLE   = 6'd6;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTIU = 6'd9;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LI    = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [2:0] ALU_ADDI  = 3'd3;
    localparam logic [2:0] ALU_SLTIU = 3'd4;
    localparam logic [2:0] ALU_ORI   = 3'd7;

    localparam logic [1:0] BT_ZERO    = 2'd0;
    localparam logic [1:0] BT_NZERO   = 2'd1;
    localparam logic [1:0] BT_NEG_ZER = 2'd2;
    localparam logic [1:0] BT_NEG     = 2'd3;

    localparam logic [1:0] DST_RT  = 2'd0;
    localparam logic [1:0] DST_RD  = 2'd1;
    localparam logic [1:0] DST_R31 = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_IMM = 2'd2;
    localparam logic [1:0] WB_PC  = 2'd3;

    localparam logic       SRCA_PC = 1'b0;
    localparam logic       SRCA_RS = 1'b1;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Opcodes that need an EXEC cycle after DECODE.
    function automatic logic needs_exec(input logic [5:0] op);
        case (op)
            OP_R, OP_BLTZ, OP_BEQ, OP_BNE, OP_BLE,
            OP_ADDI, OP_SLTIU, OP_ORI, OP_LW, OP_SW: needs_exec = 1'b1;
            default:                                  needs_exec = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle CPU control FSM (fetch/decode/exec/mem/wb)
module multi_cycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter logic [2:0] ADD_OP = 3'd3,
    parameter logic [2:0] R_OP   = 3'd2,
    parameter logic [2:0] BR_OP  = 3'd1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] instr_op_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] pc_src_o,
    output logic       branch_o,
    output logic [1:0] branch_type_o,
    output logic [2:0] state_o,
    output logic       done_o,
    output logic       illegal_o
);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= instr_op_i;
            end
        end
    end

    assign state_o = state_q;

    always_comb begin
        state_d       = state_q;
        pc_write_o    = 1'b0;
        ir_write_o    = 1'b0;
        iord_o        = 1'b0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        reg_write_o   = 1'b0;
        reg_dst_o     = DST_RT;
        mem_to_reg_o  = WB_ALU;
        alu_src_a_o   = SRCA_PC;
        alu_src_b_o   = SRCB_RT;
        alu_op_o      = 3'd0;
        pc_src_o      = PCSRC_ALU;
        branch_o      = 1'b0;
        branch_type_o = BT_ZERO;
        done_o        = 1'b0;
        illegal_o     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                alu_op_o    = ADD_OP;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_DECODE;
                end
            end

            S_DECODE: begin
                alu_src_b_o = SRCB_IMM_SH2;
                alu_op_o    = ADD_OP;
                // The opcode register is only loaded at the end of this cycle,
                // so decode looks straight at the freshly loaded IR field.
                case (instr_op_i)
                    OP_J, OP_JAL: begin
                        pc_write_o = 1'b1;
                        pc_src_o   = PCSRC_JUMP;
                        done_o     = 1'b1;
                        state_d    = S_FETCH;
                        if (instr_op_i == OP_JAL) begin
                            reg_write_o  = 1'b1;
                            reg_dst_o    = DST_R31;
                            mem_to_reg_o = WB_PC;
                        end
                    end
                    OP_LI: begin
                        reg_write_o  = 1'b1;
                        reg_dst_o    = DST_RT;
                        mem_to_reg_o = WB_IMM;
                        done_o       = 1'b1;
                        state_d      = S_FETCH;
                    end
                    default: begin
                        if (needs_exec(instr_op_i)) begin
                            state_d = S_EXEC;
                        end else begin
                            illegal_o = 1'b1;
                            done_o    = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                endcase
            end

            S_EXEC: begin
                alu_src_a_o = SRCA_RS;
                case (op_q)
                    OP_R: begin
                        alu_src_b_o = SRCB_RT;
                        alu_op_o    = R_OP;
                        state_d     = S_WB;
                    end
                    OP_ADDI, OP_SLTIU, OP_ORI: begin
                        alu_src_b_o = SRCB_IMM;
                        alu_op_o    = (op_q == OP_ADDI)  ? ALU_ADDI  :
                                      (op_q == OP_SLTIU) ? ALU_SLTIU : ALU_ORI;
                        state_d     = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b_o = SRCB_IMM;
                        alu_op_o    = ADD_OP;
                        state_d     = S_MEM;
                    end
                    OP_BEQ, OP_BNE, OP_BLE, OP_BLTZ: begin
                        alu_src_b_o   = SRCB_RT;
                        alu_op_o      = BR_OP;
                        branch_o      = 1'b1;
                        pc_src_o      = PCSRC_ALUOUT;
                        branch_type_o = (op_q == OP_BEQ) ? BT_ZERO    :
                                        (op_q == OP_BNE) ? BT_NZERO   :
                                        (op_q == OP_BLE) ? BT_NEG_ZER : BT_NEG;
                        done_o        = 1'b1;
                        state_d       = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                iord_o = 1'b1;
                case (op_q)
                    OP_LW: begin
                        mem_read_o = 1'b1;
                        if (mem_ready_i) begin
                            state_d = S_WB;
                        end
                    end
                    OP_SW: begin
                        mem_write_o = 1'b1;
                        if (mem_ready_i) begin
                            done_o  = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_WB: begin
                reg_write_o = 1'b1;
                done_o      = 1'b1;
                state_d     = S_FETCH;
                if (op_q == OP_R) begin
                    reg_dst_o = DST_RD;
                end else if (op_q == OP_LW) begin
                    mem_to_reg_o = WB_MEM;
                end
            end

            default: state_d = S_FETCH;
        endcase
    end

endmodule
